// File: rtl/vec4_fp_add_sequencer_pkg.sv
// Shared definitions for the vec4 half-precision add/subtract sequencer:
// vector geometry, FSM state encoding and the in-flight tag layout.
package vec4_fp_add_sequencer_pkg;

  localparam int VEC_COMPONENTS = 4;
  localparam int COMP_W         = 16;
  localparam int SIGN_BIT       = 15;
  localparam int IDX_W          = 2;
  localparam int TAG_W          = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/vec4_fp_add_sequencer_tag_pipe.sv
// fp_tag_pipe: fixed-depth shift register carrying {valid, idx} tags in step
// with the external adder pipeline, so each adder result can be routed to its
// vector component.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset, clears every stage
//   tag_i  - tag entering the pipe this cycle
//   tag_o  - tag leaving the pipe (aligned with the adder result)
module fp_tag_pipe #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] tag_i,
  output logic [WIDTH-1:0] tag_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vec4_fp_add_sequencer.sv
// vec4_fp_add_sequencer: feeds one vec4 add/subtract through a shared
// pipelined half-precision adder, one component per clock, and reassembles
// the result vector with OR-ed exception flags.
// Ports:
//   clock, reset             - clock and async active-high reset
//   in_valid/in_ready        - request handshake (ready only when idle)
//   in_vec_a/in_vec_b/in_sub - operand vectors, subtract select
//   add_operand_a/b          - registered operands to the adder
//   add_result, add_*        - adder result and flags, ADD_LATENCY later
//   out_valid/out_ready      - result handshake
//   out_vec, out_* flags     - assembled result and aggregated flags
//   out_zero_mask            - per-component zero flag
//   busy                     - operation in progress
//
// state    | meaning
// ST_IDLE  | waiting for a request, in_ready high
// ST_ISSUE | sending components 0..3 to the adder
// ST_DRAIN | waiting for the component 3 result
// ST_DONE  | holding the result until out_ready
module vec4_fp_add_sequencer
  import vec4_fp_add_sequencer_pkg::*;
#(
  parameter int ADD_LATENCY = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [VEC_COMPONENTS*COMP_W-1:0] in_vec_a,
  input  logic [VEC_COMPONENTS*COMP_W-1:0] in_vec_b,
  input  logic                       in_sub,
  output logic [COMP_W-1:0]          add_operand_a,
  output logic [COMP_W-1:0]          add_operand_b,
  input  logic [COMP_W-1:0]          add_result,
  input  logic                       add_overflow,
  input  logic                       add_underflow,
  input  logic                       add_zero,
  input  logic                       add_infinity,
  input  logic                       add_nan,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [VEC_COMPONENTS*COMP_W-1:0] out_vec,
  output logic                       out_overflow,
  output logic                       out_underflow,
  output logic                       out_infinity,
  output logic                       out_nan,
  output logic [VEC_COMPONENTS-1:0]  out_zero_mask,
  output logic                       busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COMPONENTS - 1);

  state_e                            state_q;
  logic [VEC_COMPONENTS*COMP_W-1:0]  vec_a_q, vec_b_q, out_vec_q;
  logic                              sub_q;
  logic [IDX_W-1:0]                  idx_q;
  logic [COMP_W-1:0]                 op_a_q, op_b_q;
  logic                              out_valid_q;
  logic                              ovf_q, unf_q, inf_q, nan_q;
  logic [VEC_COMPONENTS-1:0]         zero_mask_q;

  tag_t        tag_in, tag_out;
  logic [TAG_W-1:0] tag_out_raw;

  // A tag is pushed in the same edge the operands are registered.
  assign tag_in  = '{valid: (state_q == ST_ISSUE), idx: idx_q};
  assign tag_out = tag_t'(tag_out_raw);

  fp_tag_pipe #(
    .DEPTH (ADD_LATENCY),
    .WIDTH (TAG_W)
  ) u_tag_pipe (
    .clock (clock),
    .reset (reset),
    .tag_i (tag_in),
    .tag_o (tag_out_raw)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vec_a_q     <= '0;
      vec_b_q     <= '0;
      sub_q       <= 1'b0;
      idx_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inf_q       <= 1'b0;
      nan_q       <= 1'b0;
      zero_mask_q <= '0;
    end else begin
      // Result capture is driven by the tag alone, so it also runs while
      // later components are still being issued (short adder latency).
      if (tag_out.valid) begin
        out_vec_q[{tag_out.idx, 4'b0000} +: COMP_W] <= add_result;
        ovf_q                    <= ovf_q | add_overflow;
        unf_q                    <= unf_q | add_underflow;
        inf_q                    <= inf_q | add_infinity;
        nan_q                    <= nan_q | add_nan;
        zero_mask_q[tag_out.idx] <= add_zero;
      end

      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            vec_a_q     <= in_vec_a;
            vec_b_q     <= in_vec_b;
            sub_q       <= in_sub;
            idx_q       <= '0;
            out_vec_q   <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
            zero_mask_q <= '0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          op_a_q <= vec_a_q[{idx_q, 4'b0000} +: COMP_W];
          op_b_q <= vec_b_q[{idx_q, 4'b0000} +: COMP_W]
                    ^ (COMP_W'(sub_q) << SIGN_BIT);
          idx_q  <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (tag_out.valid && tag_out.idx == LAST_IDX) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign add_operand_a = op_a_q;
  assign add_operand_b = op_b_q;
  assign out_valid     = out_valid_q;
  assign out_vec       = out_vec_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_infinity  = inf_q;
  assign out_nan       = nan_q;
  assign out_zero_mask = zero_mask_q;

endmodule

// File: tb/tb_vec4_fp_add_sequencer.sv
module tb_vec4_fp_add_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] in_vec_a = '0;
  logic [63:0] in_vec_b = '0;

  logic        in_ready [3];
  logic [15:0] add_operand_a [3];
  logic [15:0] add_operand_b [3];
  logic [15:0] add_result [3];
  logic        add_overflow [3], add_underflow [3], add_zero [3];
  logic        add_infinity [3], add_nan [3];
  logic        out_valid [3];
  logic [63:0] out_vec [3];
  logic        out_overflow [3], out_underflow [3], out_infinity [3], out_nan [3];
  logic [3:0]  out_zero_mask [3];
  logic        busy [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  function automatic int lat_of(int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 6;
    endcase
  endfunction

  vec4_fp_add_sequencer #(.ADD_LATENCY(4)) u_dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_vec_a(in_vec_a), .in_vec_b(in_vec_b), .in_sub(in_sub),
    .add_operand_a(add_operand_a[0]), .add_operand_b(add_operand_b[0]),
    .add_result(add_result[0]), .add_overflow(add_overflow[0]),
    .add_underflow(add_underflow[0]), .add_zero(add_zero[0]),
    .add_infinity(add_infinity[0]), .add_nan(add_nan[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_vec(out_vec[0]),
    .out_overflow(out_overflow[0]), .out_underflow(out_underflow[0]),
    .out_infinity(out_infinity[0]), .out_nan(out_nan[0]),
    .out_zero_mask(out_zero_mask[0]), .busy(busy[0]));

  vec4_fp_add_sequencer #(.ADD_LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_vec_a(in_vec_a), .in_vec_b(in_vec_b), .in_sub(in_sub),
    .add_operand_a(add_operand_a[1]), .add_operand_b(add_operand_b[1]),
    .add_result(add_result[1]), .add_overflow(add_overflow[1]),
    .add_underflow(add_underflow[1]), .add_zero(add_zero[1]),
    .add_infinity(add_infinity[1]), .add_nan(add_nan[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_vec(out_vec[1]),
    .out_overflow(out_overflow[1]), .out_underflow(out_underflow[1]),
    .out_infinity(out_infinity[1]), .out_nan(out_nan[1]),
    .out_zero_mask(out_zero_mask[1]), .busy(busy[1]));

  vec4_fp_add_sequencer #(.ADD_LATENCY(6)) u_dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_vec_a(in_vec_a), .in_vec_b(in_vec_b), .in_sub(in_sub),
    .add_operand_a(add_operand_a[2]), .add_operand_b(add_operand_b[2]),
    .add_result(add_result[2]), .add_overflow(add_overflow[2]),
    .add_underflow(add_underflow[2]), .add_zero(add_zero[2]),
    .add_infinity(add_infinity[2]), .add_nan(add_nan[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_vec(out_vec[2]),
    .out_overflow(out_overflow[2]), .out_underflow(out_underflow[2]),
    .out_infinity(out_infinity[2]), .out_nan(out_nan[2]),
    .out_zero_mask(out_zero_mask[2]), .busy(busy[2]));

  // ---------------- half-precision arithmetic via real numbers -------------
  function automatic real pow2(int n);
    real p = 1.0;
    if (n >= 0) for (int k = 0; k < n; k++) p = p * 2.0;
    else        for (int k = 0; k < -n; k++) p = p / 2.0;
    return p;
  endfunction

  function automatic real h2r(logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) v = real'(h[9:0]) / 16777216.0;
    else v = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic int rne(real q);
    real fl = $floor(q);
    real d  = q - fl;
    int  i  = int'(fl);
    if (d > 0.5 || (d == 0.5 && (i % 2) == 1)) i++;
    return i;
  endfunction

  function automatic logic [15:0] r2h(real r);
    logic s = (r < 0.0);
    real  a = s ? -r : r;
    real  m;
    int   e = 0;
    int   fr;
    if (a == 0.0) return {s, 15'd0};
    if (a >= 65520.0) return {s, 5'h1F, 10'd0};
    m = a;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    if (e < -14) begin
      fr = rne(a * 16777216.0);
      return {s, 15'(fr)};
    end
    fr = rne((m - 1.0) * 1024.0);
    if (fr == 1024) begin fr = 0; e++; end
    if (e > 15) return {s, 5'h1F, 10'd0};
    return {s, 5'(e + 15), 10'(fr)};
  endfunction

  // Returns {overflow, underflow, zero, infinity, nan, result[15:0]}.
  function automatic logic [20:0] fp_add(logic [15:0] a, logic [15:0] b);
    logic a_nan = (&a[14:10]) && (|a[9:0]);
    logic b_nan = (&b[14:10]) && (|b[9:0]);
    logic a_inf = (&a[14:10]) && !(|a[9:0]);
    logic b_inf = (&b[14:10]) && !(|b[9:0]);
    real  r;
    logic [15:0] res;
    logic ovf;
    if (a_nan || b_nan || (a_inf && b_inf && a[15] != b[15]))
      return {5'b00001, 16'h7E00};
    if (a_inf || b_inf) return {5'b00010, (a_inf ? a : b)};
    r   = h2r(a) + h2r(b);
    res = r2h(r);
    ovf = &res[14:10];
    return {ovf, (r != 0.0) && (res[14:10] == 5'd0), (res[14:0] == 15'd0),
            ovf, 1'b0, res};
  endfunction

  // ---------------- adder model: result valid ADD_LATENCY clocks later -----
  logic [15:0] dla [3][6];
  logic [15:0] dlb [3][6];
  logic [20:0] res_pk [3];

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      dla[i][0] <= add_operand_a[i];
      dlb[i][0] <= add_operand_b[i];
      for (int k = 1; k < 6; k++) begin
        dla[i][k] <= dla[i][k-1];
        dlb[i][k] <= dlb[i][k-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      res_pk[i] = '0;
      if (lat_of(i) == 1) res_pk[i] = fp_add(add_operand_a[i], add_operand_b[i]);
      else res_pk[i] = fp_add(dla[i][lat_of(i)-2], dlb[i][lat_of(i)-2]);
      add_result[i]    = res_pk[i][15:0];
      add_nan[i]       = res_pk[i][16];
      add_infinity[i]  = res_pk[i][17];
      add_zero[i]      = res_pk[i][18];
      add_underflow[i] = res_pk[i][19];
      add_overflow[i]  = res_pk[i][20];
    end
  end

  // ---------------- reference expectation and checking ---------------------
  logic [63:0] exp_vec;
  logic        exp_ovf, exp_unf, exp_inf, exp_nan;
  logic [3:0]  exp_zm;

  int          got_lat [3];
  logic [63:0] got_vec [3];
  logic [3:0]  got_flags [3];
  logic [3:0]  got_zm [3];

  task automatic compute_expected(input logic [63:0] a, input logic [63:0] b,
                                  input logic sub);
    logic [20:0] r;
    exp_vec = '0; exp_ovf = 0; exp_unf = 0; exp_inf = 0; exp_nan = 0; exp_zm = '0;
    for (int k = 0; k < 4; k++) begin
      r = fp_add(a[16*k +: 16], b[16*k +: 16] ^ (sub ? 16'h8000 : 16'h0000));
      exp_vec[16*k +: 16] = r[15:0];
      exp_nan   |= r[16];
      exp_inf   |= r[17];
      exp_zm[k]  = r[18];
      exp_unf   |= r[19];
      exp_ovf   |= r[20];
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Issues one request to all three DUTs (out_ready=1) and checks latency,
  // result, flags and the return to idle for each.
  task automatic run_op(input string name, input logic [63:0] a,
                        input logic [63:0] b, input logic sub);
    compute_expected(a, b, sub);
    for (int i = 0; i < 3; i++) got_lat[i] = -1;
    @(negedge clock);
    in_vec_a = a; in_vec_b = b; in_sub = sub; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check({name, " busy_after_accept"}, 64'(busy[0]), 64'd1);
    check({name, " in_ready_after_accept"}, 64'(in_ready[0]), 64'd0);
    for (int t = 1; t <= 14; t++) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        if (got_lat[i] < 0 && out_valid[i]) begin
          got_lat[i]   = t;
          got_vec[i]   = out_vec[i];
          got_flags[i] = {out_overflow[i], out_underflow[i], out_infinity[i], out_nan[i]};
          got_zm[i]    = out_zero_mask[i];
        end else if (got_lat[i] >= 0 && t == got_lat[i] + 1) begin
          check($sformatf("%s L%0d valid_drop", name, lat_of(i)), 64'(out_valid[i]), 64'd0);
          check($sformatf("%s L%0d idle_ready", name, lat_of(i)), 64'(in_ready[i]), 64'd1);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s L%0d latency", name, lat_of(i)), 64'(got_lat[i]), 64'(4 + lat_of(i)));
      check($sformatf("%s L%0d vec", name, lat_of(i)), got_vec[i], exp_vec);
      check($sformatf("%s L%0d flags", name, lat_of(i)), 64'(got_flags[i]),
            64'({exp_ovf, exp_unf, exp_inf, exp_nan}));
      check($sformatf("%s L%0d zero_mask", name, lat_of(i)), 64'(got_zm[i]), 64'(exp_zm));
    end
  endtask

  initial begin
    logic all_valid;
    // reset state
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst out_valid", 64'(out_valid[i]), 64'd0);
      check("rst out_vec", out_vec[i], 64'd0);
      check("rst operands", {32'd0, add_operand_a[i], add_operand_b[i]}, 64'd0);
      check("rst flags", 64'({out_overflow[i], out_underflow[i], out_infinity[i],
                              out_nan[i], out_zero_mask[i]}), 64'd0);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst in_ready", 64'(in_ready[0]), 64'd1);
    check("post_rst busy", 64'(busy[0]), 64'd0);

    // directed add
    run_op("add", 64'h4400_4200_4000_3C00, 64'h3C00_3C00_3C00_3C00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("add L%0d const_vec", lat_of(i)), got_vec[i], 64'h4500_4400_4200_4000);
      check($sformatf("add L%0d const_zm", lat_of(i)), 64'(got_zm[i]), 64'd0);
    end

    // directed subtract to zero
    run_op("sub", 64'h4000_4000_4000_4000, 64'h4000_4000_4000_4000, 1'b1);
    check("sub const_vec", got_vec[0], 64'd0);
    check("sub const_zm", 64'(got_zm[0]), 64'hF);

    // NaN in comp2, overflow in comp0
    run_op("nan_ovf", 64'h3C00_7E00_3C00_7BFF, 64'h3C00_3C00_3C00_7BFF, 1'b0);
    check("nan_ovf const_flags", 64'(got_flags[0]), 64'b1011);
    check("nan_ovf comp0", 64'(got_vec[0][15:0]), 64'h7C00);

    // back-pressure
    compute_expected(64'h4400_4200_4000_3C00, 64'hBC00_3C00_BC00_3C00, 1'b1);
    out_ready = 1'b0;
    @(negedge clock);
    in_vec_a = 64'h4400_4200_4000_3C00; in_vec_b = 64'hBC00_3C00_BC00_3C00;
    in_sub = 1'b1; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    all_valid = 1'b0;
    for (int t = 0; t < 20 && !all_valid; t++) begin
      @(negedge clock);
      all_valid = out_valid[0] && out_valid[1] && out_valid[2];
    end
    check("bp all_valid", 64'(all_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_vec_a = {$urandom, $urandom};
      @(negedge clock);
      check("bp hold_valid", 64'(out_valid[0]), 64'd1);
      check("bp hold_vec", out_vec[0], exp_vec);
      check("bp hold_flags", 64'({out_overflow[0], out_underflow[0], out_infinity[0],
                                  out_nan[0], out_zero_mask[0]}),
            64'({exp_ovf, exp_unf, exp_inf, exp_nan, exp_zm}));
      check("bp in_ready", 64'(in_ready[0]), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("bp released_valid", 64'(out_valid[0]), 64'd0);
    check("bp released_ready", 64'(in_ready[0]), 64'd1);
    @(negedge clock);
    check("bp stays_idle", 64'({busy[0], busy[1], busy[2]}), 64'd0);

    // reset during ISSUE at idx=2
    @(negedge clock);
    in_vec_a = 64'h5000_5000_5000_5000; in_vec_b = 64'h4C00_4C00_4C00_4C00;
    in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort out_valid", 64'(out_valid[0]), 64'd0);
    check("abort out_vec", out_vec[0], 64'd0);
    check("abort operands", {32'd0, add_operand_a[0], add_operand_b[0]}, 64'd0);
    check("abort busy", 64'(busy[0]), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    run_op("after_abort", 64'h3800_3800_3800_3800, 64'h3400_3400_3400_3400, 1'b0);

    // randomized requests
    for (int n = 0; n < 8; n++) begin
      run_op($sformatf("rnd%0d", n), {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vec4_fp_add_sequencer.md
Name: vec4_fp_add_sequencer

Overview:
Sequences 4-component half-precision vector add/subtract operations through one shared, pipelined fp_adder_16_bit instance in the vertex shader datapath. It accepts a vec4 pair over a valid/ready handshake and issues one component per clock to the adder. It tracks in-flight components with a tag pipeline matched to the adder latency, then returns the assembled vec4 with aggregated exception flags. Only one vector operation is in flight at a time.

Parameters:
ADD_LATENCY, 4, clocks from operands presented on add_operand_a/b to the matching add_result/flags being valid (minimum 1)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  high only in IDLE
in_vec_a  input  64  operand vector A; component k at bits [16k+15:16k]
in_vec_b  input  64  operand vector B, same packing
in_sub  input  1  1 = A - B; implemented by inverting bit 15 of each B component
add_operand_a  output  16  to adder operand_a
add_operand_b  output  16  to adder operand_b (sign-adjusted)
add_result  input  16  from adder result
add_overflow, add_underflow, add_zero, add_infinity, add_nan  input  1 each  adder flags, aligned with add_result
out_valid  output  1  result vector valid
out_ready  input  1  consumer accepts the result
out_vec  output  64  result vector, same packing
out_overflow, out_underflow, out_infinity, out_nan  output  1 each  OR of the four component flags
out_zero_mask  output  4  bit k = add_zero for component k
busy  output  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE; out_valid=0, out_vec=0, all out flags and out_zero_mask=0; add_operand_a/b=0; tag pipeline cleared; component index=0. in_ready=1 and busy=0 once reset is released.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge E0, latch in_vec_a, in_vec_b and in_sub; go to ISSUE with idx=0; clear result and flag registers.
- ISSUE: each cycle drive latched component idx (B sign-flipped if sub) and push tag {valid=1, idx} into an ADD_LATENCY-deep shift register. idx increments 0..3. After idx=3 is issued, go to DRAIN. Operands stay registered (stable for the whole cycle).
- The tag emerging from the shift register marks add_result/flags as belonging to that idx. At that edge, write out_vec[idx], OR the flags in, and set out_zero_mask[idx].
- DRAIN: wait until the idx=3 tag has been captured, then go to DONE with out_valid=1. Latency: out_valid rises after edge E0+4+ADD_LATENCY (edge 8 at default).
- DONE: hold out_valid, out_vec and flags stable until out_ready=1. On the edge where out_valid&&out_ready, deassert out_valid and return to IDLE. A new request can be accepted at the earliest 1 cycle after the handshake (no same-cycle accept).
- in_valid while busy is ignored (in_ready=0). out_ready while not DONE has no effect.
- Reset mid-operation: immediate abort, tags flushed, no partial result emitted. Adder results returning after reset have no valid tag and are discarded.
- Adder operand outputs hold their last value outside ISSUE. The adder must ignore them when no tag is present.

Decomposition:
- Shared package: VEC_COMPONENTS=4, COMP_W=16, SIGN_BIT=15, state enum encoding, tag width (valid + 2-bit idx).
- One natural sub-module: fp_tag_pipe (parameterised depth=ADD_LATENCY, width=3 shift register with async reset).

Test Plan:
- Add: A={0x4400,0x4200,0x4000,0x3C00} (comp3..0 = 4,3,2,1), B=all 0x3C00, out_ready=1 -> out_vec={0x4500,0x4400,0x4200,0x4000}; out_valid at edge E0+8; all flags 0; zero_mask=0.
- Subtract A=B={0x4000 x4}, in_sub=1 -> out_vec=0, out_zero_mask=4'hF, other flags 0.
- NaN in comp2 (A=0x7E00) plus overflow in comp0 (0x7BFF+0x7BFF) -> out_nan=1, out_overflow=1, out_infinity=1; comp0=0x7C00.
- Back-pressure: out_ready=0 for 5 cycles after out_valid -> out_valid/out_vec/flags stable, in_ready=0, in_valid ignored; raise out_ready -> one handshake, then IDLE.
- Reset asserted during ISSUE at idx=2 -> all outputs 0 immediately. A fresh request then completes correctly with no stale components from the aborted request.
- Repeat the add test with ADD_LATENCY=1 and ADD_LATENCY=6 -> out_valid at E0+5 and E0+10 respectively, identical results.
